// File: rtl/gf180mcu_osu_sc_gp9t3v3__aoi21_bist.sv
// BIST controller for an aoi21 test cell: sweeps all {A0,A1,B} vectors, samples Y
// after a programmable settle time, and records mismatch count and the first failing vector.
module gf180mcu_osu_sc_gp9t3v3__aoi21_bist #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       START,
    input  logic       ABORT,
    input  logic       Y_DUT,
    output logic       A0_DUT,
    output logic       A1_DUT,
    output logic       B_DUT,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] ERR_CNT,
    output logic       FAIL_VLD,
    output logic [2:0] FAIL_VEC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_SETTLE    = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LP_LAST_LOOP = 2'(LOOPS - 1);

    state_t     r_state;
    logic [2:0] r_vec;
    logic [3:0] r_cnt;
    logic [1:0] r_loop;
    logic [3:0] r_err;
    logic       r_fvld;
    logic [2:0] r_fvec;
    logic       r_busy;
    logic       r_done;

    logic       w_exp_y;
    logic       w_mismatch;

    assign w_exp_y    = ~((r_vec[2] & r_vec[1]) | r_vec[0]);
    assign w_mismatch = (Y_DUT != w_exp_y);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_loop  <= '0;
            r_err   <= '0;
            r_fvld  <= 1'b0;
            r_fvec  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_state <= S_RUN;
                        r_vec   <= '0;
                        r_cnt   <= LP_SETTLE;
                        r_loop  <= '0;
                        r_err   <= '0;
                        r_fvld  <= 1'b0;
                        r_fvec  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Abort wins over a sample landing on the same edge.
                    if (ABORT) begin
                        r_state <= S_IDLE;
                        r_vec   <= '0;
                        r_err   <= '0;
                        r_fvld  <= 1'b0;
                        r_fvec  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (w_mismatch) begin
                            if (r_err != 4'hF) begin
                                r_err <= r_err + 4'd1;
                            end
                            if (!r_fvld) begin
                                r_fvld <= 1'b1;
                                r_fvec <= r_vec;
                            end
                        end
                        if (r_vec != 3'd7) begin
                            r_vec <= r_vec + 3'd1;
                            r_cnt <= LP_SETTLE;
                        end else if (r_loop != LP_LAST_LOOP) begin
                            r_vec  <= '0;
                            r_loop <= r_loop + 2'd1;
                            r_cnt  <= LP_SETTLE;
                        end else begin
                            r_state <= S_DONE;
                            r_vec   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign A0_DUT   = r_vec[2];
    assign A1_DUT   = r_vec[1];
    assign B_DUT    = r_vec[0];
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign PASS     = r_done & (r_err == '0);
    assign ERR_CNT  = r_err;
    assign FAIL_VLD = r_fvld;
    assign FAIL_VEC = r_fvec;

endmodule
